// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO on a register-file memory with a registered head
// stage, occupancy thresholds, synchronous flush and a high-watermark monitor.
module ram_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   max_level,
    input  logic                  clr_max
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic AEMPTY_RST = (AEMPTY_LEVEL >= 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_max;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_wr_ready;
    logic                  w_rd_valid;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic [ADDR_WIDTH:0]   w_wr_ptr_next;
    logic [ADDR_WIDTH:0]   w_rd_ptr_next;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH:0]   w_max_next;
    logic [DATA_WIDTH-1:0] w_head_next;

    always_comb begin
        w_wr_ready = (r_count != DEPTH_C);
        w_rd_valid = (r_count != '0);
        w_do_wr    = wr_valid && w_wr_ready && !flush;
        w_do_rd    = rd_ready && w_rd_valid && !flush;

        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_do_wr) w_wr_ptr_next = r_wr_ptr + ONE_C;
            if (w_do_rd) w_rd_ptr_next = r_rd_ptr + ONE_C;
            if (w_do_wr && !w_do_rd)      w_count_next = r_count + ONE_C;
            else if (!w_do_wr && w_do_rd) w_count_next = r_count - ONE_C;
        end

        // The word being written this edge becomes the head when the queue was
        // empty after the pop; bypass the memory so it is visible next cycle.
        if (w_do_wr && (w_rd_ptr_next == r_wr_ptr))
            w_head_next = wr_data;
        else
            w_head_next = r_mem[w_rd_ptr_next[ADDR_WIDTH-1:0]];

        w_max_next = r_max;
        if (flush)
            w_max_next = '0;
        else if (clr_max)
            w_max_next = w_count_next;
        else if (w_count_next > r_max)
            w_max_next = w_count_next;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_do_wr)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_max     <= '0;
            r_rd_data <= '0;
            r_afull   <= 1'b0;
            r_aempty  <= AEMPTY_RST;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_max    <= w_max_next;
            r_afull  <= (w_count_next >= AFULL_C);
            r_aempty <= (w_count_next <= AEMPTY_C);
            // Head register holds its value across a flush.
            if (!flush)
                r_rd_data <= w_head_next;
        end
    end

    assign wr_ready     = w_wr_ready;
    assign rd_valid     = w_rd_valid;
    assign rd_data      = r_rd_data;
    assign count        = r_count;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign max_level    = r_max;

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo: reset, fill/drain, streaming, boundaries,
// flush and threshold/watermark behaviour with hand-computed expectations.
module tb_ram_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  max_level;
    logic        clr_max;

    int errors = 0;
    int checks = 0;

    ram_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_level    (max_level),
        .clr_max      (clr_max)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; clr_max = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hDEAD; rd_ready = 1'b0;
        repeat (3) step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %0b exp 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %0b exp 0", rd_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %0b exp 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %0b exp 0", almost_full); end
        checks++; if (max_level !== 5'd0) begin errors++; $display("FAIL rst_max: got %0d exp 0", max_level); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd_data: got %0h exp 0", rd_data); end
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got count=%0d valid=%0b exp 0/0", count, rd_valid); end
        $display("reset done");
    endtask

    task automatic test_fill_drain();
        rd_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            wr_valid = 1'b1; wr_data = 32'(i);
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %0b exp 1", i, wr_ready); end
            step();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count, i); end
            checks++; if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_afull[%0d]: got %0b exp %0b", i, almost_full, (i >= 12)); end
            $display("write %0h count=%0d", wr_data, count);
        end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b exp 0", wr_ready); end
        wr_data = 32'h11;
        step();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL held_off: got %0d exp 16", count); end
        checks++; if (max_level !== 5'd16) begin errors++; $display("FAIL fill_max: got %0d exp 16", max_level); end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(i)) begin errors++; $display("FAIL drain[%0d]: got valid=%0b data=%0h exp 1/%0h", i, rd_valid, rd_data, i); end
            $display("read %0h", rd_data);
            step();
        end
        checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL drain_empty: got valid=%0b count=%0d exp 0/0", rd_valid, count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_stream();
        clr_max = 1'b1;
        step();
        clr_max = 1'b0;
        checks++; if (max_level !== 5'd0) begin errors++; $display("FAIL clr_at_empty: got %0d exp 0", max_level); end
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 32'(100 + i);
            if (i > 0) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(99 + i)) begin errors++; $display("FAIL stream[%0d]: got valid=%0b data=%0d exp 1/%0d", i, rd_valid, rd_data, 99 + i); end
                $display("stream read %0d", rd_data);
            end
            step();
            checks++; if (count !== 5'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d exp 1", i, count); end
        end
        wr_valid = 1'b0;
        checks++; if (rd_data !== 32'd139) begin errors++; $display("FAIL stream_last: got %0d exp 139", rd_data); end
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_end: got %0d exp 0", count); end
        checks++; if (max_level !== 5'd1) begin errors++; $display("FAIL stream_max: got %0d exp 1", max_level); end
        rd_ready = 1'b0;
    endtask

    task automatic test_boundary();
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 32'(200 + i);
            step();
        end
        wr_data = 32'h999; rd_ready = 1'b1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_rw_ready: got %0b exp 0", wr_ready); end
        step();
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_rw_count: got %0d exp 15", count); end
        checks++; if (rd_data !== 32'd201) begin errors++; $display("FAIL full_rw_head: got %0d exp 201", rd_data); end
        rd_ready = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reopen_ready: got %0b exp 1", wr_ready); end
        step();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL reopen_count: got %0d exp 16", count); end
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            checks++; if (rd_data !== 32'(200 + i)) begin errors++; $display("FAIL bnd_drain[%0d]: got %0d exp %0d", i, rd_data, 200 + i); end
            step();
        end
        checks++; if (count !== 5'd1 || rd_data !== 32'h999) begin errors++; $display("FAIL one_left: got count=%0d data=%0h exp 1/999", count, rd_data); end
        wr_valid = 1'b1; wr_data = 32'hABC;
        step();
        checks++; if (count !== 5'd1 || rd_data !== 32'hABC) begin errors++; $display("FAIL one_rw: got count=%0d data=%0h exp 1/abc", count, rd_data); end
        wr_valid = 1'b0;
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL bnd_empty: got %0d exp 0", count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1; wr_data = 32'(300 + i);
            step();
        end
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL pre_flush: got %0d exp 7", count); end
        flush = 1'b1; wr_valid = 1'b1; wr_data = 32'h777; rd_ready = 1'b1;
        step();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got count=%0d valid=%0b exp 0/0", count, rd_valid); end
        checks++; if (max_level !== 5'd0) begin errors++; $display("FAIL flush_max: got %0d exp 0", max_level); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b exp 1", wr_ready); end
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_discard: got %0d exp 0", count); end
        wr_valid = 1'b1; wr_data = 32'h55;
        step();
        wr_valid = 1'b0;
        checks++; if (count !== 5'd1 || rd_data !== 32'h55) begin errors++; $display("FAIL post_flush: got count=%0d data=%0h exp 1/55", count, rd_data); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        $display("flush done");
    endtask

    task automatic test_thresholds();
        clr_max = 1'b1;
        step();
        clr_max = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            wr_valid = 1'b1; wr_data = 32'(400 + i);
            step();
            checks++; if (almost_empty !== (i <= 2) || almost_full !== (i >= 12)) begin errors++; $display("FAIL thr_up[%0d]: got ae=%0b af=%0b exp %0b/%0b", i, almost_empty, almost_full, (i <= 2), (i >= 12)); end
        end
        wr_valid = 1'b0;
        checks++; if (max_level !== 5'd13) begin errors++; $display("FAIL wm_13: got %0d exp 13", max_level); end
        rd_ready = 1'b1;
        for (int c = 12; c >= 5; c--) begin
            step();
            checks++; if (count !== 5'(c) || almost_full !== (c >= 12) || almost_empty !== 1'b0) begin errors++; $display("FAIL thr_dn[%0d]: got cnt=%0d af=%0b ae=%0b", c, count, almost_full, almost_empty); end
        end
        rd_ready = 1'b0;
        checks++; if (max_level !== 5'd13) begin errors++; $display("FAIL wm_hold: got %0d exp 13", max_level); end
        clr_max = 1'b1;
        step();
        clr_max = 1'b0;
        checks++; if (max_level !== 5'd5) begin errors++; $display("FAIL wm_clr: got %0d exp 5", max_level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_boundary();
        test_flush();
        test_thresholds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
